inst_fetch: RTL and testbench

Instruction-fetch front end that drives the instruction memory's word-address port and consumes its combinational read data. It holds the fetch program counter and a small prefetch FIFO of {pc, instruction} pairs, and presents instructions to decode through a valid/ready handshake. A redirect from execute (branch or jump) flushes the FIFO and restarts fetch at the new target. It sits between the instruction memory and the decode stage of the milestone-2 RV32I core.

---
 rtl/inst_fetch_if.sv | 23 ++
 rtl/inst_fetch.sv | 94 +++++++++
 tb/tb_inst_fetch.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-side bus: instruction memory port, execute redirect, decode handshake.
interface inst_fetch_if;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_ready;

  // Fetch unit side.
  modport master (
    output o_imem_addr, o_valid, o_instr, o_pc,
    input  i_imem_rdata, i_redirect, i_redirect_pc, i_ready
  );

  // Environment side (memory, execute, decode).
  modport slave (
    input  o_imem_addr, o_valid, o_instr, o_pc,
    output i_imem_rdata, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: fetch PC, prefetch FIFO of {pc, instr} pairs,
// valid/ready handshake to decode, and flush-and-restart on redirect.

// One prefetch slot. Storage is deliberately unreset; occupancy lives in count.
module inst_fetch_entry (
  input  logic        clk,
  input  logic        we,
  input  logic [63:0] d,
  output logic [63:0] q
);
  // Capture the {pc, instr} pair when this slot is the write target.
  always_ff @(posedge clk)
    if (we) q <= d;
endmodule

module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic          i_clk,
  input  logic          i_reset,
  inst_fetch_if.master  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]   fetch_pc;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          pop, push, full;

  fetch_entry_t                    wr_data;
  logic [FIFO_DEPTH-1:0]           ent_we;
  logic [FIFO_DEPTH-1:0][63:0]     ent_q;
  fetch_entry_t                    head;

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = bus.o_valid & bus.i_ready;
  // A pop frees a slot in the same cycle, so a full FIFO keeps streaming.
  assign push = ~bus.i_redirect & (~full | pop);

  assign wr_data.pc    = fetch_pc;
  assign wr_data.instr = bus.i_imem_rdata;

  // Per-slot storage with one-hot write enable from wr_ptr.
  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_ent
    assign ent_we[g] = push & (wr_ptr == AW'(g));
    inst_fetch_entry u_ent (
      .clk (i_clk),
      .we  (ent_we[g]),
      .d   (wr_data),
      .q   (ent_q[g])
    );
  end

  assign head = ent_q[rd_ptr];

  // Occupancy update; redirect flushes everything regardless of push/pop.
  always_comb begin
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    if (bus.i_redirect) count_next = '0;
  end

  // Fetch PC, pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (bus.i_redirect) begin
      fetch_pc <= {bus.i_redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;  // wraps modulo 2^32
        wr_ptr   <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end

  assign bus.o_imem_addr = fetch_pc;
  assign bus.o_valid     = (count != '0);
  assign bus.o_instr     = bus.o_valid ? head.instr : NOP_INSTR;
  assign bus.o_pc        = bus.o_valid ? head.pc    : 32'h0;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stimulus pushes expected decode transactions,
// a negedge monitor pops and compares on every accepted handshake.
module tb_inst_fetch;
  logic i_clk = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb[$];
  logic [63:0] e;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .NOP_INSTR(32'h13)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  // Memory image: word k holds 32'h1000_0000 + k.
  assign bus.i_imem_rdata = 32'h1000_0000 + {2'b00, bus.o_imem_addr[31:2]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_tx(input logic [31:0] pc, input logic [31:0] instr);
    sb.push_back({pc, instr});
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every handshake that decode actually consumes.
  always @(negedge i_clk)
    if (!i_reset && bus.o_valid && bus.i_ready && !bus.i_redirect) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_accept: got pc %h expected none", bus.o_pc);
      end else begin
        e = sb.pop_front();
        chk("acc_pc", bus.o_pc, e[63:32]);
        chk("acc_instr", bus.o_instr, e[31:0]);
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_reset           = 1'b1;
    bus.i_ready       = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    repeat (2) step();
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_instr", bus.o_instr, 32'h13);
    chk("rst_pc", bus.o_pc, 32'h0);
    chk("rst_addr", bus.o_imem_addr, 32'h0);
    chk("rst_count", 32'(dut.count), 32'h0);

    // Stream from reset, stall with head at 8, then full-with-pop streaming.
    expect_tx(32'h0,  32'h1000_0000);
    expect_tx(32'h4,  32'h1000_0001);
    expect_tx(32'h8,  32'h1000_0002);
    expect_tx(32'hC,  32'h1000_0003);
    expect_tx(32'h10, 32'h1000_0004);
    i_reset = 1'b0;                              // C0
    chk("c0_valid", 32'(bus.o_valid), 32'h0);
    step();                                      // C1
    chk("c1_valid", 32'(bus.o_valid), 32'h1);
    chk("c1_pc", bus.o_pc, 32'h0);
    step();                                      // C2
    step();                                      // C3
    bus.i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_pc", bus.o_pc, 32'h8);
      if (k > 0) begin
        chk("stall_addr", bus.o_imem_addr, 32'h10);
        chk("stall_count", 32'(dut.count), 32'h2);
      end
      step();
    end
    bus.i_ready = 1'b1;                          // C8
    chk("full_pop_count", 32'(dut.count), 32'h2);
    step();                                      // C9
    chk("full_pop_count", 32'(dut.count), 32'h2);
    chk("full_pop_pc", bus.o_pc, 32'hC);
    step();                                      // C10
    chk("full_pop_count", 32'(dut.count), 32'h2);
    step();                                      // C11: full, head 20

    // Redirect while full with i_ready=1; misaligned target.
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0103;
    expect_tx(32'h100, 32'h1000_0040);
    expect_tx(32'h104, 32'h1000_0041);
    step();                                      // C12
    bus.i_redirect = 1'b0;
    chk("redir_valid", 32'(bus.o_valid), 32'h0);
    chk("redir_addr", bus.o_imem_addr, 32'h100);
    step();                                      // C13
    chk("redir_head_valid", 32'(bus.o_valid), 32'h1);
    step();                                      // C14
    step();                                      // C15

    // Redirect near the top of the address space to exercise wrap.
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'hFFFF_FFF8;
    expect_tx(32'hFFFF_FFF8, 32'h4FFF_FFFE);
    expect_tx(32'hFFFF_FFFC, 32'h4FFF_FFFF);
    expect_tx(32'h0000_0000, 32'h1000_0000);
    expect_tx(32'h0000_0004, 32'h1000_0001);
    step();                                      // C16
    bus.i_redirect = 1'b0;
    chk("wrap_valid", 32'(bus.o_valid), 32'h0);
    chk("wrap_addr", bus.o_imem_addr, 32'hFFFF_FFF8);
    step();                                      // C17
    chk("wrap_head", bus.o_pc, 32'hFFFF_FFF8);
    repeat (3) step();                           // C20
    step();                                      // C21
    bus.i_ready = 1'b0;
    step();                                      // C22
    chk("pre_reset_count", 32'(dut.count), 32'h2);
    chk("pre_reset_pc", bus.o_pc, 32'h8);

    // Mid-stream asynchronous reset.
    i_reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.o_valid), 32'h0);
    chk("mid_rst_instr", bus.o_instr, 32'h13);
    chk("mid_rst_addr", bus.o_imem_addr, 32'h0);
    chk("mid_rst_pc", bus.o_pc, 32'h0);
    expect_tx(32'h0, 32'h1000_0000);
    expect_tx(32'h4, 32'h1000_0001);
    expect_tx(32'h8, 32'h1000_0002);
    step();
    i_reset     = 1'b0;                          // R0
    bus.i_ready = 1'b1;
    chk("restart_valid", 32'(bus.o_valid), 32'h0);
    repeat (3) step();                           // R1..R3
    step();                                      // R4
    bus.i_ready = 1'b0;
    repeat (2) step();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
